// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice per cycle, WIDTH/4 cycles per sum.
// Optional signed-overflow output OVF is built when the NSA_OVF_EN macro is defined.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic [1:0]       state_dbg,
    output logic             Cout
`ifdef NSA_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int NS = WIDTH / 4;
    localparam int KW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic            carry;
    logic [KW-1:0]   k;

    logic [3:0] a_sl;
    logic [3:0] b_sl;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] sum_sl;

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in DONE.
    assign in_ready  = (state == IDLE);
    assign state_dbg = state;

    always_comb begin
        a_sl = 4'(a_reg >> {k, 2'b00});
        b_sl = 4'(b_reg >> {k, 2'b00});
        g    = a_sl & b_sl;
        p    = a_sl ^ b_sl;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum_sl = p ^ c[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            k         <= '0;
            S         <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef NSA_OVF_EN
            OVF       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= A;
                        b_reg <= B;
                        carry <= Cin;
                        k     <= '0;
                        S     <= '0;
                        Cout  <= 1'b0;
`ifdef NSA_OVF_EN
                        OVF   <= 1'b0;
`endif
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // S was cleared at capture, so OR-ing each slice into place is enough.
                    S     <= S | (WIDTH'(sum_sl) << {k, 2'b00});
                    carry <= c[4];
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
                        Cout      <= c[4];
`ifdef NSA_OVF_EN
                        OVF       <= c[3] ^ c[4];
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL provide parameter: WIDTH, 16, operand/sum width in bits; legal values are multiples of 4 with WIDTH >= 8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand set A/B/Cin is valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands; high exactly when state is IDLE.
REQ-006 SHALL have port: A  input  WIDTH  operand A, sampled only on input handshake.
REQ-007 SHALL have port: B  input  WIDTH  operand B, sampled only on input handshake.
REQ-008 SHALL have port: Cin  input  1  carry-in, sampled only on input handshake.
REQ-009 SHALL have port: out_valid  output  1  S/Cout hold a completed result.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port: S  output  WIDTH  registered sum.
REQ-012 SHALL have port: Cout  output  1  registered carry-out of the MSB.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, BUSY, DONE.
REQ-014 IDLE: on an edge with in_valid=1, SHALL capture A, B, Cin, clear the slice counter to 0, clear the sum register and go to BUSY; otherwise it SHALL stay in IDLE.
REQ-015 BUSY: each cycle SHALL add slice k (bits 4k+3..4k) of A and B plus the carry register using one 4-bit carry-lookahead slice (g=a&b, p=a^b, c[i+1]=g[i]|p[i]&c[i], fully expanded).
REQ-016 BUSY: each cycle SHALL write the 4 result bits into S bits 4k+3..4k, load the slice carry-out into the carry register and increment k.
REQ-017 The carry register SHALL be loaded with Cin at capture; slice 0 SHALL use it.
REQ-018 After slice WIDTH/4-1, the FSM SHALL go to DONE; Cout SHALL equal the final slice carry-out.
REQ-019 Latency: with capture on edge N, out_valid SHALL rise after edge N+WIDTH/4 (4 cycles for WIDTH=16).
REQ-020 DONE: out_valid=1; S and Cout SHALL stay stable while out_ready=0, for any duration.
REQ-021 DONE with out_ready=1 on an edge: SHALL go to IDLE; out_valid SHALL drop after that edge; S/Cout SHALL hold their values until the next capture.
REQ-022 in_valid in BUSY or DONE SHALL be ignored; operand inputs SHALL not affect an operation in progress.
REQ-023 Result SHALL equal (A+B+Cin) mod 2^WIDTH, with Cout = bit WIDTH of the full sum, for all operand values.
REQ-024 Throughput: one operation per WIDTH/4+2 cycles at most, with out_ready tied high.

Reset
REQ-025 While rst=1 (asynchronous), state SHALL be IDLE; S, Cout, out_valid, carry register and slice counter SHALL be 0.
REQ-026 While rst=1, in_ready SHALL be 1 and no capture SHALL occur.
REQ-027 rst asserted in BUSY or DONE SHALL abort the operation; no partial result SHALL ever be presented with out_valid=1.

Configuration
REQ-028 Macro NSA_OVF_EN defined: SHALL add port OVF  output  1, signed two's-complement overflow.
REQ-029 With NSA_OVF_EN, OVF SHALL equal carry into the MSB XOR Cout; it SHALL be registered with S, reset to 0 and held like S.
REQ-030 Without NSA_OVF_EN, the port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-031 WIDTH=16, A=0xFFFF, B=0x0001, Cin=0 -> after 4 BUSY cycles: S=0x0000, Cout=1, out_valid=1.
REQ-032 A=0x1234, B=0x4321, Cin=1 -> S=0x5556, Cout=0; A/B changed during BUSY -> result unchanged.
REQ-033 Hold out_ready=0 for 3 cycles in DONE -> out_valid, S, Cout stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-034 Assert rst after 2 BUSY cycles of 0xAAAA+0x5555 -> S=0, Cout=0, out_valid=0, in_ready=1 immediately; next operation correct.
REQ-035 NSA_OVF_EN defined, A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, OVF=1; A=0x8000, B=0x8000 -> S=0x0000, Cout=1, OVF=1.
REQ-036 Random sweep of 10000 operand sets with random out_ready stalls -> every S/Cout matches the reference sum.
